light_sequencer: RTL and testbench
==================================

// Module: light_sequencer
// PURPOSE
//  Consumes the registered 2-bit traffic mode and drives the main-street and side-street lamps plus the walk lamp.
//  Moore FSM with a tick-driven phase timer. Mode codes, in priority order: 11 emergency > 10 pedestrian > 01 night > 00 day.
//  Sits directly downstream of the traffic-mode register, in the same clk domain.
// PARAMETERS
//  CNT_W    8  phase-timer width; every duration below must be >=1 and <=2**CNT_W-1
//  GREEN_T  20 green duration, in ticks
//  YELLOW_T 4  yellow duration, in ticks
//  ALLRED_T 2  all-red clearance duration, in ticks
//  WALK_T   10 walk duration, in ticks (both streets red)
//  FLASH_T  1  night-flash half-period, in ticks
// PORTS
//  clk          in  1 system clock, rising edge
//  rst          in  1 synchronous, active-high reset
//  tick         in  1 one-cycle timebase enable; the timer advances only when tick=1
//  traffic_mode in  2 mode from upstream: 00 day, 01 night, 10 ped, 11 emergency
//  main_light   out 3 {R,Y,G}, one-hot except during night flash
//  side_light   out 3 {R,Y,G}
//  walk         out 1 pedestrian walk lamp
//  ped_ack      out 1 one-cycle pulse on the cycle WALK is entered
// BEHAVIOUR
//  - States: MAIN_G, MAIN_Y, AR1, SIDE_G, SIDE_Y, AR2, WALK, FLASH, EMG.
//  - Outputs are a decode of the state register (Moore), so they change on the clk edge that changes the state.
//    - Any state not showing green or yellow on a street shows red on that street.
//    - walk=1 only in WALK.
//  - Timer
//    - On entry to a phase, cnt loads DUR-1.
//    - On each tick with cnt>0, cnt decrements.
//    - The phase ends on a tick with cnt==0, so a phase lasts exactly DUR ticks.
//    - tick=0 freezes cnt and the state, except for emergency entry.
//  - Day cycle: MAIN_G -> MAIN_Y -> AR1 -> SIDE_G -> SIDE_Y -> AR2 -> MAIN_G.
//  - Pedestrian request
//    - ped_pending is set on any cycle with mode==10, so single-cycle requests are not lost.
//    - It is cleared on WALK entry or on rst.
//    - In a green state with ped_pending=1: cnt is forced to 0, so green ends at the next tick.
//    - AR1 or AR2 end with ped_pending=1 -> WALK. WALK end -> AR2.
//  - Night
//    - AR1 or AR2 end with mode==01 and ped_pending=0 -> FLASH.
//    - In FLASH, flash_on starts at 1 and toggles every FLASH_T ticks.
//      - main_light={0,flash_on,0}, side_light={flash_on,0,0}.
//    - mode!=01 at a tick -> AR2 (a pending ped request then routes through WALK via AR2).
//  - Emergency
//    - mode==11 in any non-EMG state -> EMG on the next clk edge, independent of tick.
//    - EMG shows all red, walk=0.
//    - Held while mode==11. First cycle with mode!=11 -> AR2 (full ALLRED_T), then normal sequencing.
//    - ped_pending is preserved across EMG.
//    - Emergency during WALK aborts the walk immediately.
//  - Simultaneous events: emergency beats a timer expiry in the same cycle. rst beats everything.
//  - Reset (also mid-phase)
//    - state=AR2, cnt=ALLRED_T-1, ped_pending=0, flash_on=1.
//    - Outputs after reset: main_light=100, side_light=100, walk=0, ped_ack=0.
//  - Invalid state encodings recover to AR2 on the next clk.
// CONFIGURATION
//  YELLOW_ON_EMG_EN
//    - Defined: mode==11 while in MAIN_G or SIDE_G first goes to that street's yellow (full YELLOW_T), then EMG.
//      Yellow-state timing is unchanged. All other states go directly to EMG.
//    - Undefined: every state goes directly to EMG on the next clk edge.
// TESTING
//  (GREEN_T=3, YELLOW_T=2, ALLRED_T=1, WALK_T=4, FLASH_T=1, tick=1 every cycle unless noted)
//  1. Day cycle: rst, then mode=00.
//     -> AR2 1 cycle; main G 3, Y 2; AR1 1; side G 3, Y 2; AR2 1; 12-cycle period repeats.
//  2. Emergency: mode=11 for 5 cycles at MAIN_G cycle 1.
//     -> macro off: all red the next cycle; macro on: main Y 2 cycles, then all red.
//     -> On release: AR2 1 cycle, then MAIN_G.
//  3. Pedestrian: mode=10 for 1 cycle during SIDE_G cycle 0.
//     -> side Y next, 2 cycles; AR2 1; walk=1 4 cycles with ped_ack pulsing on the first; AR2 1; MAIN_G.
//  4. Night: mode=01 held from MAIN_G.
//     -> after AR1, FLASH: main 010/000 and side 100/000 alternate each cycle.
//     -> mode=00: AR2 1 cycle, then MAIN_G.
//  5. tick held 0 in MAIN_G -> state frozen.
//     rst asserted mid-WALK -> next cycle main=side=100, walk=0, ped_pending=0.

Source files
------------

// File: rtl/light_sequencer_if.sv
// ---------------------------------------------------------------------------
// light_sequencer_if
//   Groups the traffic-mode inputs and the lamp outputs of light_sequencer.
//   Clock and reset stay plain ports on the module itself.
//
//   tick          1  one-cycle timebase enable (driven toward the sequencer)
//   traffic_mode  2  00 day, 01 night, 10 pedestrian, 11 emergency
//   main_light    3  main-street lamps {R,Y,G}
//   side_light    3  side-street lamps {R,Y,G}
//   walk          1  pedestrian walk lamp
//   ped_ack       1  one-cycle pulse on the cycle the walk phase is entered
//
//   master : upstream side (mode register / bench), drives tick and mode
//   slave  : the sequencer, drives the lamps
// ---------------------------------------------------------------------------
interface light_sequencer_if;
  logic       tick;
  logic [1:0] traffic_mode;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_ack;

  modport master (
    output tick,
    output traffic_mode,
    input  main_light,
    input  side_light,
    input  walk,
    input  ped_ack
  );

  modport slave (
    input  tick,
    input  traffic_mode,
    output main_light,
    output side_light,
    output walk,
    output ped_ack
  );
endinterface

// File: rtl/light_sequencer.sv
// ---------------------------------------------------------------------------
// light_sequencer
//   Moore traffic-light controller. Consumes the registered 2-bit traffic mode
//   and drives main/side street lamps plus the walk lamp. Phases are timed by
//   a down-counter that only advances on tick. Mode priority:
//   emergency > pedestrian > night > day.
//
// Ports
//   clk   in  system clock, rising edge
//   rst   in  synchronous, active-high reset
//   bus   light_sequencer_if.slave
//           tick, traffic_mode        (in)
//           main_light, side_light,   (out, {R,Y,G})
//           walk, ped_ack             (out)
//
// Parameters
//   CNT_W, GREEN_T, YELLOW_T, ALLRED_T, WALK_T, FLASH_T (durations in ticks,
//   each 1 .. 2**CNT_W-1)
//
// Build option
//   YELLOW_ON_EMG_EN  when defined, an emergency arriving during a green runs
//                     that street's full yellow before going all-red. When
//                     undefined, every state goes straight to EMG.
//
// All lamp outputs are registered: they are decoded from the next state so
// they change on the same clock edge as the state register.
// ---------------------------------------------------------------------------
module light_sequencer #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10,
  parameter int FLASH_T  = 1
) (
  input  logic             clk,
  input  logic             rst,
  light_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    ST_MAIN_G = 4'd0,
    ST_MAIN_Y = 4'd1,
    ST_AR1    = 4'd2,
    ST_SIDE_G = 4'd3,
    ST_SIDE_Y = 4'd4,
    ST_AR2    = 4'd5,
    ST_WALK   = 4'd6,
    ST_FLASH  = 4'd7,
    ST_EMG    = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);

  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

`ifdef YELLOW_ON_EMG_EN
  localparam logic EMG_VIA_YELLOW = 1'b1;
`else
  localparam logic EMG_VIA_YELLOW = 1'b0;
`endif

  // Registered state
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ped_pending_q;
  logic             ped_pending_d;
  logic             flash_on_q;
  logic             flash_on_d;
  // Set while a yellow was entered because of an emergency: that yellow
  // is allowed to run out and then goes to EMG instead of all-red.
  logic             emg_yel_q;
  logic             emg_yel_d;

  // Registered outputs
  logic [2:0]       main_light_q;
  logic [2:0]       main_light_d;
  logic [2:0]       side_light_q;
  logic [2:0]       side_light_d;
  logic             walk_q;
  logic             walk_d;
  logic             ped_ack_q;
  logic             ped_ack_d;

  // Input qualifiers
  logic             tick;
  logic [1:0]       mode;
  logic             emg_req;
  logic             timer_done;
  logic [CNT_W-1:0] cnt_step;

  assign tick       = bus.tick;
  assign mode       = bus.traffic_mode;
  assign emg_req    = (mode == MODE_EMG);
  assign timer_done = tick && (cnt_q == CNT_ZERO);
  // Value the timer takes when the phase does not end this cycle.
  assign cnt_step   = tick ? (cnt_q - CNT_ONE) : cnt_q;

  // Lamp decode of a state: {main_light, side_light, walk}.
  function automatic logic [6:0] lamp_decode(input state_t st, input logic flash_on);
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    m = LAMP_R;
    s = LAMP_R;
    w = 1'b0;
    case (st)
      ST_MAIN_G: m = LAMP_G;
      ST_MAIN_Y: m = LAMP_Y;
      ST_SIDE_G: s = LAMP_G;
      ST_SIDE_Y: s = LAMP_Y;
      ST_WALK:   w = 1'b1;
      ST_FLASH: begin
        m = {1'b0, flash_on, 1'b0};
        s = {flash_on, 2'b00};
      end
      default: begin
        m = LAMP_R;
        s = LAMP_R;
        w = 1'b0;
      end
    endcase
    return {m, s, w};
  endfunction

  // State, timer, request latch and lamp output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_AR2;
      cnt_q         <= ALLRED_LD;
      ped_pending_q <= 1'b0;
      flash_on_q    <= 1'b1;
      emg_yel_q     <= 1'b0;
      main_light_q  <= LAMP_R;
      side_light_q  <= LAMP_R;
      walk_q        <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      flash_on_q    <= flash_on_d;
      emg_yel_q     <= emg_yel_d;
      main_light_q  <= main_light_d;
      side_light_q  <= side_light_d;
      walk_q        <= walk_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  // Next-state, timer and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flash_on_d    = flash_on_q;
    emg_yel_d     = emg_yel_q;
    // A request is latched on any cycle it is seen; WALK entry clears it.
    ped_pending_d = ped_pending_q | (mode == MODE_PED);

    case (state_q)
      ST_MAIN_G, ST_SIDE_G: begin
        if (emg_req) begin
          if (EMG_VIA_YELLOW) begin
            state_d   = (state_q == ST_MAIN_G) ? ST_MAIN_Y : ST_SIDE_Y;
            cnt_d     = YELLOW_LD;
            emg_yel_d = 1'b1;
          end else begin
            state_d = ST_EMG;
            cnt_d   = CNT_ZERO;
          end
        end else if (tick && (ped_pending_q || (cnt_q == CNT_ZERO))) begin
          state_d = (state_q == ST_MAIN_G) ? ST_MAIN_Y : ST_SIDE_Y;
          cnt_d   = YELLOW_LD;
        end else if (ped_pending_q) begin
          // Pending walk request cuts the green short at the next tick.
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_step;
        end
      end

      ST_MAIN_Y, ST_SIDE_Y: begin
        if (emg_req && !emg_yel_q) begin
          state_d = ST_EMG;
          cnt_d   = CNT_ZERO;
        end else if (timer_done) begin
          if (emg_yel_q) begin
            state_d   = ST_EMG;
            cnt_d     = CNT_ZERO;
            emg_yel_d = 1'b0;
          end else begin
            state_d = (state_q == ST_MAIN_Y) ? ST_AR1 : ST_AR2;
            cnt_d   = ALLRED_LD;
          end
        end else begin
          cnt_d = cnt_step;
        end
      end

      ST_AR1, ST_AR2: begin
        if (emg_req) begin
          state_d = ST_EMG;
          cnt_d   = CNT_ZERO;
        end else if (timer_done) begin
          if (ped_pending_q) begin
            state_d       = ST_WALK;
            cnt_d         = WALK_LD;
            ped_pending_d = 1'b0;
          end else if (mode == MODE_NIGHT) begin
            state_d    = ST_FLASH;
            cnt_d      = FLASH_LD;
            flash_on_d = 1'b1;
          end else begin
            state_d = (state_q == ST_AR1) ? ST_SIDE_G : ST_MAIN_G;
            cnt_d   = GREEN_LD;
          end
        end else begin
          cnt_d = cnt_step;
        end
      end

      ST_WALK: begin
        if (emg_req) begin
          state_d = ST_EMG;
          cnt_d   = CNT_ZERO;
        end else if (timer_done) begin
          state_d = ST_AR2;
          cnt_d   = ALLRED_LD;
        end else begin
          cnt_d = cnt_step;
        end
      end

      ST_FLASH: begin
        if (emg_req) begin
          state_d = ST_EMG;
          cnt_d   = CNT_ZERO;
        end else if (tick && (mode != MODE_NIGHT)) begin
          // Leaving night goes through clearance; a pending walk is then
          // served from AR2.
          state_d = ST_AR2;
          cnt_d   = ALLRED_LD;
        end else if (timer_done) begin
          flash_on_d = ~flash_on_q;
          cnt_d      = FLASH_LD;
        end else begin
          cnt_d = cnt_step;
        end
      end

      ST_EMG: begin
        // Release does not wait for a tick; clearance starts at full length.
        if (!emg_req) begin
          state_d = ST_AR2;
          cnt_d   = ALLRED_LD;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end

      default: begin
        state_d    = ST_AR2;
        cnt_d      = ALLRED_LD;
        emg_yel_d  = 1'b0;
        flash_on_d = 1'b1;
      end
    endcase

    {main_light_d, side_light_d, walk_d} = lamp_decode(state_d, flash_on_d);
    ped_ack_d = (state_d == ST_WALK) && (state_q != ST_WALK);
  end

  assign bus.main_light = main_light_q;
  assign bus.side_light = side_light_q;
  assign bus.walk       = walk_q;
  assign bus.ped_ack    = ped_ack_q;

endmodule

// File: tb/tb_light_sequencer.sv
// ---------------------------------------------------------------------------
// tb_light_sequencer
//   Drives light_sequencer through directed scenarios and a long randomized
//   run. A behavioural model (phase name + ticks spent in the phase) predicts
//   the lamps each cycle and pushes them into a scoreboard; a monitor pops and
//   compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_light_sequencer;
  localparam int CNT_W    = 8;
  localparam int GREEN_T  = 3;
  localparam int YELLOW_T = 2;
  localparam int ALLRED_T = 1;
  localparam int WALK_T   = 4;
  localparam int FLASH_T  = 1;

`ifdef YELLOW_ON_EMG_EN
  localparam bit YEL_EMG = 1'b1;
`else
  localparam bit YEL_EMG = 1'b0;
`endif

  localparam int PH_MG    = 0;
  localparam int PH_MY    = 1;
  localparam int PH_AR1   = 2;
  localparam int PH_SG    = 3;
  localparam int PH_SY    = 4;
  localparam int PH_AR2   = 5;
  localparam int PH_WALK  = 6;
  localparam int PH_FLASH = 7;
  localparam int PH_EMG   = 8;

  localparam int SB_DEPTH = 16;
  localparam int DAY_LEN  = 14;

  // Day cycle right after reset release: AR2, G x3, Y x2, AR1, side G x3,
  // side Y x2, AR2, then the next MAIN_G (12-cycle period).
  localparam logic [2:0] DAY_MAIN [DAY_LEN] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100,
                                              3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
  localparam logic [2:0] DAY_SIDE [DAY_LEN] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                              3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

  typedef struct packed {
    logic [2:0] mlt;
    logic [2:0] slt;
    logic       wlk;
    logic       ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  light_sequencer_if bus ();

  light_sequencer #(
    .CNT_W   (CNT_W),
    .GREEN_T (GREEN_T),
    .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T),
    .WALK_T  (WALK_T),
    .FLASH_T (FLASH_T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard ring: model is the only writer of sb_mem/sb_wr, monitor of sb_rd.
  exp_t sb_mem [SB_DEPTH];
  int   sb_wr    = 0;
  int   sb_rd    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   dir_active = 1'b0;
  int   dir_idx  = 0;

  // Model state
  int m_ph     = PH_AR2;
  int m_ticks  = 0;
  int m_fticks = 0;
  bit m_ped    = 1'b0;
  bit m_ey     = 1'b0;

  function automatic int dur_of(input int ph);
    case (ph)
      PH_MG, PH_SG:   return GREEN_T;
      PH_MY, PH_SY:   return YELLOW_T;
      PH_AR1, PH_AR2: return ALLRED_T;
      PH_WALK:        return WALK_T;
      default:        return 1;
    endcase
  endfunction

  function automatic exp_t lamps_of(input int ph, input bit fl, input bit ack);
    exp_t e;
    e.mlt = 3'b100;
    e.slt = 3'b100;
    e.wlk = 1'b0;
    e.ack = ack;
    case (ph)
      PH_MG:    e.mlt = 3'b001;
      PH_MY:    e.mlt = 3'b010;
      PH_SG:    e.slt = 3'b001;
      PH_SY:    e.slt = 3'b010;
      PH_WALK:  e.wlk = 1'b1;
      PH_FLASH: begin
        e.mlt = {1'b0, fl, 1'b0};
        e.slt = {fl, 2'b00};
      end
      default: ;
    endcase
    return e;
  endfunction

  // Reference model: advances one cycle per rising edge from the sampled inputs
  always @(posedge clk) begin : ref_model
    int         ph, ticks, fticks, prev;
    bit         ped, ey, emg, is_g, is_y, fl, ack;
    logic [1:0] mode;
    exp_t       e;
    prev   = m_ph;
    ph     = m_ph;
    ticks  = m_ticks;
    fticks = m_fticks;
    ped    = m_ped;
    ey     = m_ey;
    mode   = bus.traffic_mode;
    if (rst) begin
      ph = PH_AR2; ticks = 0; fticks = 0; ped = 1'b0; ey = 1'b0; prev = PH_AR2;
    end else begin
      emg  = (mode == 2'b11);
      is_g = (ph == PH_MG) || (ph == PH_SG);
      is_y = (ph == PH_MY) || (ph == PH_SY);
      ped  = m_ped || (mode == 2'b10);
      if (emg && (ph != PH_EMG) && !(is_y && ey)) begin
        if (YEL_EMG && is_g) begin
          ph = (ph == PH_MG) ? PH_MY : PH_SY; ticks = 0; ey = 1'b1;
        end else begin
          ph = PH_EMG; ticks = 0;
        end
      end else if (ph == PH_EMG) begin
        if (!emg) begin ph = PH_AR2; ticks = 0; end
      end else if (bus.tick) begin
        if (ph == PH_FLASH) begin
          if (mode != 2'b01) begin ph = PH_AR2; ticks = 0; end
          else fticks++;
        end else if ((ticks + 1 >= dur_of(ph)) || (is_g && m_ped)) begin
          ticks = 0;
          case (ph)
            PH_MG: ph = PH_MY;
            PH_SG: ph = PH_SY;
            PH_MY: if (ey) begin ph = PH_EMG; ey = 1'b0; end else ph = PH_AR1;
            PH_SY: if (ey) begin ph = PH_EMG; ey = 1'b0; end else ph = PH_AR2;
            PH_AR1, PH_AR2: begin
              if (m_ped) begin ph = PH_WALK; ped = 1'b0; end
              else if (mode == 2'b01) begin ph = PH_FLASH; fticks = 0; end
              else ph = (ph == PH_AR1) ? PH_SG : PH_MG;
            end
            default: ph = PH_AR2;
          endcase
        end else begin
          ticks++;
        end
      end
    end
    fl  = (((fticks / FLASH_T) % 2) == 0);
    ack = !rst && (ph == PH_WALK) && (prev != PH_WALK);
    e   = lamps_of(ph, fl, ack);
    m_ph     <= ph;
    m_ticks  <= ticks;
    m_fticks <= fticks;
    m_ped    <= ped;
    m_ey     <= ey;
    sb_mem[sb_wr % SB_DEPTH] <= e;
    sb_wr    <= sb_wr + 1;
  end

  task automatic cmp(input string nm, input logic [2:0] act, input logic [2:0] exp,
                     inout int c, inout int f);
    c++;
    if (act !== exp) begin
      f++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT lamps against the scoreboard and the fixed day table
  always @(negedge clk) begin : monitor
    exp_t e;
    int   c, f;
    c = 0;
    f = 0;
    if (sb_rd != sb_wr) begin
      e = sb_mem[sb_rd % SB_DEPTH];
      cmp("main_light", bus.main_light, e.mlt, c, f);
      cmp("side_light", bus.side_light, e.slt, c, f);
      cmp("walk", {2'b00, bus.walk}, {2'b00, e.wlk}, c, f);
      cmp("ped_ack", {2'b00, bus.ped_ack}, {2'b00, e.ack}, c, f);
      sb_rd <= sb_rd + 1;
    end
    if (dir_active && (dir_idx < DAY_LEN)) begin
      cmp("day_main", bus.main_light, DAY_MAIN[dir_idx], c, f);
      cmp("day_side", bus.side_light, DAY_SIDE[dir_idx], c, f);
      dir_idx <= dir_idx + 1;
    end
    n_checks <= n_checks + c;
    n_fail   <= n_fail + f;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until lamp sel (0 main, 1 side, 2 walk) equals / differs from val.
  task automatic wait_lamp(input int sel, input logic [2:0] val, input bit eq, input string what);
    int         n;
    logic [2:0] cur;
    n = 0;
    forever begin
      cur = (sel == 0) ? bus.main_light : (sel == 1) ? bus.side_light : {2'b00, bus.walk};
      if ((cur == val) == eq) break;
      cyc();
      n++;
      if (n > 200) begin
        $display("FAIL timeout %s: waited %0d cycles, lamp %b", what, n, cur);
        $fatal(1, "bounded wait expired");
      end
    end
  endtask

  // Stimulus
  initial begin
    rst              = 1'b1;
    bus.tick         = 1'b1;
    bus.traffic_mode = 2'b00;
    repeat (2) cyc();

    // Day cycle straight out of reset, checked against the fixed table too
    rst        = 1'b0;
    dir_active = 1'b1;
    repeat (DAY_LEN) cyc();

    // Emergency for 5 cycles starting at MAIN_G cycle 1
    wait_lamp(0, 3'b001, 1'b0, "leave_green");
    wait_lamp(0, 3'b001, 1'b1, "main_green_emg");
    cyc();
    bus.traffic_mode = 2'b11;
    repeat (5) cyc();
    bus.traffic_mode = 2'b00;
    repeat (8) cyc();

    // Single-cycle pedestrian request during SIDE_G cycle 0
    wait_lamp(1, 3'b001, 1'b1, "side_green");
    bus.traffic_mode = 2'b10;
    cyc();
    bus.traffic_mode = 2'b00;
    repeat (16) cyc();

    // Night from MAIN_G, then back to day
    wait_lamp(0, 3'b001, 1'b0, "leave_green2");
    wait_lamp(0, 3'b001, 1'b1, "main_green_night");
    bus.traffic_mode = 2'b01;
    repeat (25) cyc();
    bus.traffic_mode = 2'b00;
    repeat (10) cyc();

    // Frozen timer in MAIN_G
    wait_lamp(0, 3'b001, 1'b0, "leave_green3");
    wait_lamp(0, 3'b001, 1'b1, "main_green_freeze");
    bus.tick = 1'b0;
    repeat (10) cyc();
    bus.tick = 1'b1;

    // Reset in the middle of a walk
    bus.traffic_mode = 2'b10;
    cyc();
    bus.traffic_mode = 2'b00;
    wait_lamp(2, 3'b001, 1'b1, "walk_on");
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (12) cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.tick = ($urandom_range(0, 3) != 0);
      if (r < 5) begin
        bus.traffic_mode = 2'($urandom_range(0, 3));
      end else if ((r < 15) && (bus.traffic_mode == 2'b10)) begin
        bus.traffic_mode = 2'b00;
      end else if ((r < 18) && (bus.traffic_mode == 2'b11)) begin
        bus.traffic_mode = 2'b00;
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
